watch_mode_ctrl: RTL
====================

Name: watch_mode_ctrl

Overview:
- Top-level sequencer for the digital-watch datapath with four functions: time-of-day clock (CLK), alarm setting (ALM), stopwatch (SW) and countdown (CD).
- Owns the three user buttons and routes each press only to the selected function.
- Multiplexes that function's digits onto the display, generates the shared 1 Hz tick, and pre-empts everything with a timed ringing state when an alarm fires.

Parameters:
TICK_DIV, 50000000, CLK_50 cycles per tick_1hz pulse (minimum 4, even).
RING_SECS, 30, ticks spent in RING before automatic silence (minimum 1).

Ports:
CLK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_mode  in  1  debounced, synchronised mode button level
btn_adjust  in  1  debounced, synchronised adjust button level
btn_toggle  in  1  debounced, synchronised toggle button level
fn_edit  in  4  per-function "in edit" flag, bit0=CLK, 1=ALM, 2=SW, 3=CD
clk_digits  in  24  CLK digits {H1,H0,M1,M0,S1,S0}, 4 bits each
alm_digits  in  24  ALM digits
sw_digits  in  24  SW digits
cd_digits  in  24  CD digits
alm_match  in  1  level: alarm time equals clock time
cd_zero  in  1  level: countdown has reached zero
tick_1hz  out  1  one-cycle pulse every TICK_DIV cycles
sel  out  4  one-hot selected function
p_mode  out  4  one-cycle mode pulse routed to function bit i
p_adjust  out  4  one-cycle adjust pulse routed to function bit i
p_toggle  out  4  one-cycle toggle pulse routed to function bit i
disp  out  24  digits for the display driver
blank  out  1  display blank, used for flashing
ring  out  1  buzzer enable
ring_src  out  1  0 = alarm match, 1 = countdown
ring_ack  out  1  one-cycle pulse when RING exits

Behaviour:
- Reset, asynchronous on reset_n low:
  - state CLK, sel=4'b0001.
  - All pulse outputs 0, ring=0, blank=0, ring_src=0.
  - Prescaler=0, ring counter=0, pending=0.
  - Button history registers=0 and event history registers=0.
  - Reset mid-RING drops ringing immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick_1hz=1 in the cycle the count equals TICK_DIV-1.
- Button press detection:
  - press = level & ~registered previous level.
  - A held button yields exactly one press.
  - Routed pulses are registered: 1-cycle latency from the level edge.
- Event detection:
  - ev_alm = rising edge of alm_match; ev_cd = rising edge of cd_zero.
- States: CLK, ALM, SW, CD, RING. sel is one-hot of the current function state; in RING, sel holds the saved return state.
- Function states, per press in cycle N:
  - mode press with fn_edit[sel] set: p_mode[sel] pulses in N+1, state unchanged.
  - mode press with fn_edit[sel] clear: advance CLK->ALM->SW->CD->CLK, sel updates in N+1, no p_mode pulse.
  - adjust press: p_adjust[sel] pulses in N+1.
  - toggle press: p_toggle[sel] pulses in N+1.
  - Simultaneous presses: each is routed independently. If mode advances the state, adjust and toggle in the same cycle go to the old sel.
- Entering RING:
  - Trigger: ev_alm or ev_cd in any function state.
  - Save the return state; clear the ring counter.
  - ring_src = 1 if ev_cd, else 0. If both fire in the same cycle, CD wins and ALM sets pending.
  - Button presses in the entry cycle are discarded.
- In RING:
  - ring=1; disp shows the source function's digits (alm_digits or cd_digits).
  - blank=1 while prescaler >= TICK_DIV/2, otherwise 0.
  - No p_* pulses are issued. Any press, of any button, is consumed.
  - ev_alm or ev_cd arriving during RING sets pending and records its source.
- Exiting RING:
  - Triggers: any press, or the ring counter reaching RING_SECS (counter increments on tick_1hz).
  - Next cycle: return to the saved state, ring=0, blank=0, ring_ack=1 for one cycle.
  - If pending is set, re-enter RING in the cycle after ring_ack with the pending source, then clear pending.
- Outside RING: disp = digits of sel, combinational mux; blank=0.
- ring_ack is shared; functions acknowledge only when ring_src matches.

Test Plan:
- Reset then no input for 2*TICK_DIV cycles -> sel=0001, disp=clk_digits, tick_1hz pulses at cycles TICK_DIV-1 and 2*TICK_DIV-1, all p_*=0.
- fn_edit=0, btn_mode held high for 10 cycles, 4 separate times -> sel steps 0010, 0100, 1000, 0001, one step per press, p_mode stays 0.
- sel=CD, fn_edit[3]=1, btn_mode press -> p_mode=1000 for exactly one cycle, sel stays 1000; btn_toggle press -> p_toggle=1000 one cycle.
- sel=SW, cd_zero rises -> ring=1, ring_src=1, disp=cd_digits, blank toggles every TICK_DIV/2 cycles. btn_adjust press -> p_adjust stays 0, next cycle ring=0, ring_ack=1, sel=0100.
- alm_match and cd_zero rise in the same cycle, RING_SECS=2 -> RING with ring_src=1, exit after 2 ticks with ring_ack, RING re-entered next cycle with ring_src=0.
- reset_n pulsed low mid-RING -> ring, blank and ring_ack immediately 0, sel=0001, pending cleared.

Source files
------------

// File: rtl/watch_mode_ctrl_if.sv
// Signal bundle between the watch sequencer and the function blocks, display and buzzer.
// The sequencer connects through the slave modport; the side driving buttons and digits uses master.
interface watch_mode_ctrl_if;
  logic        btn_mode;
  logic        btn_adjust;
  logic        btn_toggle;
  logic [3:0]  fn_edit;
  logic [23:0] clk_digits;
  logic [23:0] alm_digits;
  logic [23:0] sw_digits;
  logic [23:0] cd_digits;
  logic        alm_match;
  logic        cd_zero;

  logic        tick_1hz;
  logic [3:0]  sel;
  logic [3:0]  p_mode;
  logic [3:0]  p_adjust;
  logic [3:0]  p_toggle;
  logic [23:0] disp;
  logic        blank;
  logic        ring;
  logic        ring_src;
  logic        ring_ack;

  modport master (
    output btn_mode, btn_adjust, btn_toggle, fn_edit,
           clk_digits, alm_digits, sw_digits, cd_digits, alm_match, cd_zero,
    input  tick_1hz, sel, p_mode, p_adjust, p_toggle, disp, blank,
           ring, ring_src, ring_ack
  );

  modport slave (
    input  btn_mode, btn_adjust, btn_toggle, fn_edit,
           clk_digits, alm_digits, sw_digits, cd_digits, alm_match, cd_zero,
    output tick_1hz, sel, p_mode, p_adjust, p_toggle, disp, blank,
           ring, ring_src, ring_ack
  );
endinterface

// File: rtl/watch_mode_ctrl.sv
// Digital-watch sequencer: 1 Hz prescaler, button routing to the selected function,
// display multiplexing and a timed ringing state that pre-empts everything on alarm/countdown.
module watch_mode_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned RING_SECS = 30
) (
  input  logic             CLK_50,
  input  logic             reset_n,
  watch_mode_ctrl_if.slave bus
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned CNT_W = (RING_SECS < 2) ? 1 : $clog2(RING_SECS);

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF  = PRE_W'(TICK_DIV / 2);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECS - 1);

  typedef enum logic [2:0] {
    ST_CLK  = 3'd0,
    ST_ALM  = 3'd1,
    ST_SW   = 3'd2,
    ST_CD   = 3'd3,
    ST_RING = 3'd4
  } state_t;

  state_t           st_q, ret_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] ring_cnt_q;
  logic [2:0]       btn_q;
  logic             alm_q, cd_q;
  logic             pend_q, pend_src_q;
  logic [3:0]       sel_q, p_mode_q, p_adjust_q, p_toggle_q;
  logic             ring_q, ring_src_q, ring_ack_q;

  logic       tick;
  logic       press_mode, press_adjust, press_toggle, any_press;
  logic       ev_alm, ev_cd, ring_done;
  logic [1:0] fn_idx, next_idx;
  logic [3:0] fn_oh;
  logic [23:0] disp_c;

  // Function index: during RING the saved return state still names the selected function.
  assign fn_idx   = (st_q == ST_RING) ? ret_q[1:0] : st_q[1:0];
  assign next_idx = fn_idx + 2'd1;
  assign fn_oh    = 4'b0001 << fn_idx;

  always_comb begin
    tick         = (pre_q == PRE_LAST);
    pre_d        = tick ? '0 : pre_q + 1'b1;
    press_mode   = bus.btn_mode   & ~btn_q[0];
    press_adjust = bus.btn_adjust & ~btn_q[1];
    press_toggle = bus.btn_toggle & ~btn_q[2];
    any_press    = press_mode | press_adjust | press_toggle;
    ev_alm       = bus.alm_match & ~alm_q;
    ev_cd        = bus.cd_zero   & ~cd_q;
    ring_done    = tick && (ring_cnt_q == RING_LAST);
  end

  // NOTE: all state below updates with non-blocking assignments so every branch sees
  // the values from the start of the cycle, independent of statement order.
  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= ST_CLK;
      ret_q      <= ST_CLK;
      pre_q      <= '0;
      ring_cnt_q <= '0;
      btn_q      <= '0;
      alm_q      <= 1'b0;
      cd_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_src_q <= 1'b0;
      sel_q      <= 4'b0001;
      p_mode_q   <= '0;
      p_adjust_q <= '0;
      p_toggle_q <= '0;
      ring_q     <= 1'b0;
      ring_src_q <= 1'b0;
      ring_ack_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      btn_q      <= {bus.btn_toggle, bus.btn_adjust, bus.btn_mode};
      alm_q      <= bus.alm_match;
      cd_q       <= bus.cd_zero;
      p_mode_q   <= '0;
      p_adjust_q <= '0;
      p_toggle_q <= '0;
      ring_ack_q <= 1'b0;

      if (st_q == ST_RING) begin
        if (ev_alm || ev_cd) begin
          pend_q     <= 1'b1;
          pend_src_q <= ev_cd;
        end
        // Presses only silence the buzzer; they never reach a function.
        if (any_press || ring_done) begin
          st_q       <= ret_q;
          ring_q     <= 1'b0;
          ring_ack_q <= 1'b1;
        end else if (tick) begin
          ring_cnt_q <= ring_cnt_q + 1'b1;
        end
      end else if (ev_alm || ev_cd || pend_q) begin
        st_q       <= ST_RING;
        ret_q      <= st_q;
        ring_q     <= 1'b1;
        ring_cnt_q <= '0;
        // A fresh event beats a pending one; simultaneous events ring CD first.
        if (ev_cd) begin
          ring_src_q <= 1'b1;
          if (ev_alm) begin
            pend_q     <= 1'b1;
            pend_src_q <= 1'b0;
          end
        end else if (ev_alm) begin
          ring_src_q <= 1'b0;
        end else begin
          ring_src_q <= pend_src_q;
          pend_q     <= 1'b0;
        end
      end else begin
        if (press_adjust) p_adjust_q <= fn_oh;
        if (press_toggle) p_toggle_q <= fn_oh;
        if (press_mode) begin
          if (bus.fn_edit[fn_idx]) begin
            p_mode_q <= fn_oh;
          end else begin
            st_q  <= state_t'({1'b0, next_idx});
            sel_q <= 4'b0001 << next_idx;
          end
        end
      end
    end
  end

  always_comb begin
    disp_c = bus.clk_digits;
    if (st_q == ST_RING) begin
      disp_c = ring_src_q ? bus.cd_digits : bus.alm_digits;
    end else begin
      case (fn_idx)
        2'd0:    disp_c = bus.clk_digits;
        2'd1:    disp_c = bus.alm_digits;
        2'd2:    disp_c = bus.sw_digits;
        default: disp_c = bus.cd_digits;
      endcase
    end
  end

  assign bus.tick_1hz = tick;
  assign bus.sel      = sel_q;
  assign bus.p_mode   = p_mode_q;
  assign bus.p_adjust = p_adjust_q;
  assign bus.p_toggle = p_toggle_q;
  assign bus.disp     = disp_c;
  assign bus.blank    = (st_q == ST_RING) && (pre_q >= PRE_HALF);
  assign bus.ring     = ring_q;
  assign bus.ring_src = ring_src_q;
  assign bus.ring_ack = ring_ack_q;

endmodule
